// File: rtl/reg_file_pkg.sv
// Shared constants for the 16 x 32-bit register file.
// Half-select encodings pick the low or high half-word on writes.
package reg_file_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 16;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;
endpackage

// File: rtl/reg_file_mux.sv
// Combinational read mux over the packed register array.
// One instance per read port of the register file.
module rf_read_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                addr,
  output logic [DATA_W-1:0]                data
);
  assign data = regs[addr];
endmodule

// File: rtl/reg_file.sv
// 16 x 32-bit register file, half-word writes, three async reads.
// Port 3 shows the current contents of the write destination.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RF_HL,
  input  logic [ADDR_W-1:0] reg_port1,
  input  logic [ADDR_W-1:0] reg_port2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  output logic [DATA_W-1:0] reg_out1,
  output logic [DATA_W-1:0] reg_out2,
  output logic [DATA_W-1:0] reg_out3
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int HALF_W = DATA_W/2;

  logic [DEPTH-1:0][DATA_W-1:0] regs;

  // Reset wins over we; only the selected half-word moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (we) begin
      if (RF_HL == HALF_HI)
        regs[write_reg][DATA_W-1:HALF_W] <= data_in[DATA_W-1:HALF_W];
      else
        regs[write_reg][HALF_W-1:0] <= data_in[HALF_W-1:0];
    end
  end

  rf_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux1 (
    .regs(regs),
    .addr(reg_port1),
    .data(reg_out1)
  );

  rf_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux2 (
    .regs(regs),
    .addr(reg_port2),
    .data(reg_out2)
  );

  rf_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux3 (
    .regs(regs),
    .addr(write_reg),
    .data(reg_out3)
  );
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: half-word writes, reset priority,
// no write-through, and combinational tracking of all read ports.
module tb_reg_file;
  logic        clk;
  logic        reset;
  logic        RF_HL;
  logic [3:0]  reg_port1;
  logic [3:0]  reg_port2;
  logic [3:0]  write_reg;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] reg_out1;
  logic [31:0] reg_out2;
  logic [31:0] reg_out3;

  int total;
  int passed;

  reg_file dut (
    .clk(clk),
    .reset(reset),
    .RF_HL(RF_HL),
    .reg_port1(reg_port1),
    .reg_port2(reg_port2),
    .write_reg(write_reg),
    .data_in(data_in),
    .we(we),
    .reg_out1(reg_out1),
    .reg_out2(reg_out2),
    .reg_out3(reg_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pat(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {b, 8'hC3, ~b, 8'h5A};
  endfunction

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    we = 1'b0;
    RF_HL = 1'b0;
    data_in = '0;
    reg_port1 = 4'd1;
    reg_port2 = 4'd9;
    write_reg = 4'd0;
    tick();
    reset = 1'b0;
    tick();
    check("rst_out1", reg_out1, 32'h0);
    check("rst_out2", reg_out2, 32'h0);
    check("rst_out3", reg_out3, 32'h0);

    we = 1'b1;
    RF_HL = 1'b0;
    write_reg = 4'd1;
    data_in = 32'hFFFFFFFF;
    #1;
    check("no_bypass_lo", reg_out1, 32'h0);
    tick();
    check("lo_out1", reg_out1, 32'h0000FFFF);
    check("lo_out3", reg_out3, 32'h0000FFFF);
    check("lo_out2", reg_out2, 32'h0);

    RF_HL = 1'b1;
    #1;
    check("no_bypass_hi", reg_out1, 32'h0000FFFF);
    tick();
    check("hi_out1", reg_out1, 32'hFFFFFFFF);

    write_reg = 4'd9;
    data_in = 32'hAAAAAAAA;
    tick();
    check("r9_hi_out2", reg_out2, 32'hAAAA0000);
    check("r9_hi_out3", reg_out3, 32'hAAAA0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r9_hold", reg_out2, 32'hAAAA0000);
    end
    RF_HL = 1'b0;
    tick();
    check("r9_lo_out2", reg_out2, 32'hAAAAAAAA);
    check("r1_kept", reg_out1, 32'hFFFFFFFF);

    we = 1'b0;
    data_in = 32'h12345678;
    tick();
    RF_HL = 1'b1;
    tick();
    check("we0_out1", reg_out1, 32'hFFFFFFFF);
    check("we0_out2", reg_out2, 32'hAAAAAAAA);
    check("we0_out3", reg_out3, 32'hAAAAAAAA);
    reg_port1 = 4'd0;
    #1;
    check("we0_r0", reg_out1, 32'h0);

    we = 1'b1;
    RF_HL = 1'b0;
    write_reg = 4'd0;
    data_in = 32'h1234BEEF;
    tick();
    check("r0_writable", reg_out1, 32'h0000BEEF);
    check("r0_other", reg_out2, 32'hAAAAAAAA);

    reset = 1'b1;
    we = 1'b1;
    write_reg = 4'd1;
    RF_HL = 1'b1;
    data_in = 32'h55555555;
    reg_port1 = 4'd1;
    reg_port2 = 4'd9;
    tick();
    check("rstwin_out1", reg_out1, 32'h0);
    check("rstwin_out2", reg_out2, 32'h0);
    check("rstwin_out3", reg_out3, 32'h0);
    reg_port1 = 4'd0;
    #1;
    check("rstwin_r0", reg_out1, 32'h0);

    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      write_reg = 4'(k);
      data_in = pat(k);
      RF_HL = 1'b1;
      tick();
      RF_HL = 1'b0;
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 16; k++) begin
      reg_port1 = 4'(k);
      reg_port2 = 4'(15 - k);
      write_reg = 4'((k + 3) % 16);
      #1;
      check("sweep_out1", reg_out1, pat(k));
      check("sweep_out2", reg_out2, pat(15 - k));
      check("sweep_out3", reg_out3, pat((k + 3) % 16));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
